// File: rtl/dual_output_checker_if.sv
// rtl/dual_output_checker_if.sv - stimulus and result bundle for the dual-flow y-bus checker
interface dual_output_checker_if #(
  parameter int WIDTH     = 644,
  parameter int SIG_WIDTH = 32
);
  logic                 start;
  logic                 in_valid;
  logic [WIDTH-1:0]     y_ref;
  logic [WIDTH-1:0]     y_dut;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [15:0]          fail_count;
  logic [15:0]          first_fail_cycle;
  logic [9:0]           first_fail_bit;
  logic [SIG_WIDTH-1:0] sig_ref;
  logic [SIG_WIDTH-1:0] sig_dut;

  modport master (
    output start, in_valid, y_ref, y_dut,
    input  busy, done, pass, fail_count, first_fail_cycle, first_fail_bit, sig_ref, sig_dut
  );

  modport slave (
    input  start, in_valid, y_ref, y_dut,
    output busy, done, pass, fail_count, first_fail_cycle, first_fail_bit, sig_ref, sig_dut
  );
endinterface

// File: rtl/dual_output_checker.sv
// rtl/dual_output_checker.sv - compares reference and netlist y buses, tracks first failure and MISR signatures
module dual_output_checker #(
  parameter int                   WIDTH       = 644,
  parameter int                   SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF,
  parameter int                   SKIP_CYCLES = 1,
  parameter int                   MAX_CYCLES  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_output_checker_if.slave  bus
);

  localparam int NCHUNK = (WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PADW   = NCHUNK * SIG_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COMPARE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [15:0]          skip_cnt_q, skip_cnt_d;
  logic [15:0]          idx_q, idx_d;
  logic [15:0]          fail_count_q, fail_count_d;
  logic [15:0]          ffc_q, ffc_d;
  logic [9:0]           ffb_q, ffb_d;
  logic [SIG_WIDTH-1:0] sig_ref_q, sig_ref_d;
  logic [SIG_WIDTH-1:0] sig_dut_q, sig_dut_d;

  // The top chunk is zero-padded so every chunk folds at full signature width.
  function automatic logic [SIG_WIDTH-1:0] fold(input logic [WIDTH-1:0] y);
    logic [PADW-1:0]      p;
    logic [SIG_WIDTH-1:0] f;
    p = PADW'(y);
    f = '0;
    for (int c = 0; c < NCHUNK; c++) f = f ^ p[c*SIG_WIDTH +: SIG_WIDTH];
    return f;
  endfunction

  function automatic logic [SIG_WIDTH-1:0] misr(input logic [SIG_WIDTH-1:0] sig,
                                                input logic [WIDTH-1:0] y);
    return {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ fold(y);
  endfunction

  function automatic logic [9:0] lowest_bit(input logic [WIDTH-1:0] diff);
    logic [9:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (diff[i]) idx = 10'(i);
    return idx;
  endfunction

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    skip_cnt_d   = skip_cnt_q;
    idx_d        = idx_q;
    fail_count_d = fail_count_q;
    ffc_d        = ffc_q;
    ffb_d        = ffb_q;
    sig_ref_d    = sig_ref_q;
    sig_dut_d    = sig_dut_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = (SKIP_CYCLES == 0) ? S_COMPARE : S_WARMUP;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          skip_cnt_d   = '0;
          idx_d        = '0;
          fail_count_d = '0;
          ffc_d        = 16'hFFFF;
          ffb_d        = '0;
          sig_ref_d    = SEED;
          sig_dut_d    = SEED;
        end
      end
      S_WARMUP: begin
        if (bus.in_valid) begin
          skip_cnt_d = skip_cnt_q + 16'd1;
          if (skip_cnt_q == 16'(SKIP_CYCLES - 1)) state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (bus.in_valid) begin
          if (bus.y_ref != bus.y_dut) begin
            if (fail_count_q != 16'hFFFF) fail_count_d = fail_count_q + 16'd1;
            if (ffc_q == 16'hFFFF) begin
              ffc_d = idx_q;
              ffb_d = lowest_bit(bus.y_ref ^ bus.y_dut);
            end
          end
          sig_ref_d = misr(sig_ref_q, bus.y_ref);
          sig_dut_d = misr(sig_dut_q, bus.y_dut);
          idx_d     = idx_q + 16'd1;
          if (idx_q == 16'(MAX_CYCLES - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_count_d == 16'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      skip_cnt_q   <= '0;
      idx_q        <= '0;
      fail_count_q <= '0;
      ffc_q        <= 16'hFFFF;
      ffb_q        <= '0;
      sig_ref_q    <= SEED;
      sig_dut_q    <= SEED;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      skip_cnt_q   <= skip_cnt_d;
      idx_q        <= idx_d;
      fail_count_q <= fail_count_d;
      ffc_q        <= ffc_d;
      ffb_q        <= ffb_d;
      sig_ref_q    <= sig_ref_d;
      sig_dut_q    <= sig_dut_d;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fail_count_q;
  assign bus.first_fail_cycle = ffc_q;
  assign bus.first_fail_bit   = ffb_q;
  assign bus.sig_ref          = sig_ref_q;
  assign bus.sig_dut          = sig_dut_q;

endmodule

// File: tb/tb_dual_output_checker.sv
// tb/tb_dual_output_checker.sv - scoreboard bench for dual_output_checker
module tb_dual_output_checker;
  localparam int          W    = 644;
  localparam int          SKIP = 1;
  localparam int          MAX  = 20;
  localparam int          NS   = SKIP + MAX;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dual_output_checker_if #(.WIDTH(W), .SIG_WIDTH(32)) b0 ();
  dual_output_checker_if #(.WIDTH(W), .SIG_WIDTH(32)) b1 ();

  dual_output_checker #(.WIDTH(W), .SIG_WIDTH(32), .POLY(POLY), .SEED(SEED),
                        .SKIP_CYCLES(SKIP), .MAX_CYCLES(MAX))
    dut (.clk(clk), .rst(rst), .bus(b0));

  dual_output_checker #(.WIDTH(W), .SIG_WIDTH(32), .POLY(POLY), .SEED(SEED),
                        .SKIP_CYCLES(0), .MAX_CYCLES(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic [15:0] fc;
    logic [15:0] ffc;
    logic [9:0]  ffb;
    logic [31:0] sr;
    logic [31:0] sd;
    logic        pass;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  logic         done_prev = 1'b0;
  logic [W-1:0] ref_v [NS];
  logic [W-1:0] dut_v [NS];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [671:0] t;
    for (int c = 0; c < 21; c++) t[c*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  // Reference MISR: bit i of y lands in signature bit (i mod 32).
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < W; i++) f[i % 32] = f[i % 32] ^ y[i];
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] s_r;
    logic [31:0] s_d;
    int          i;
    s_r = SEED; s_d = SEED;
    e.fc = 0; e.ffc = 16'hFFFF; e.ffb = 0;
    for (int j = 0; j < MAX; j++) begin
      if (ref_v[SKIP+j] != dut_v[SKIP+j]) begin
        if (e.fc != 16'hFFFF) e.fc = e.fc + 1;
        if (e.ffc == 16'hFFFF) begin
          e.ffc = 16'(j);
          i = 0;
          while (ref_v[SKIP+j][i] == dut_v[SKIP+j][i]) i++;
          e.ffb = 10'(i);
        end
      end
      s_r = misr_step(s_r, ref_v[SKIP+j]);
      s_d = misr_step(s_d, dut_v[SKIP+j]);
    end
    e.sr = s_r; e.sd = s_d;
    e.pass = (e.fc == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (b0.done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        mon_e = sb.pop_front();
        chk("fail_count", b0.fail_count, mon_e.fc);
        chk("first_fail_cycle", b0.first_fail_cycle, mon_e.ffc);
        chk("first_fail_bit", b0.first_fail_bit, mon_e.ffb);
        chk("sig_ref", b0.sig_ref, mon_e.sr);
        chk("sig_dut", b0.sig_dut, mon_e.sd);
        chk("pass", b0.pass, mon_e.pass);
      end
    end
    done_prev = b0.done;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, b0.busy, 0);
    chk({tag, "_done"}, b0.done, 0);
    chk({tag, "_pass"}, b0.pass, 0);
    chk({tag, "_fail_count"}, b0.fail_count, 0);
    chk({tag, "_first_fail_cycle"}, b0.first_fail_cycle, 16'hFFFF);
    chk({tag, "_first_fail_bit"}, b0.first_fail_bit, 0);
    chk({tag, "_sig_ref"}, b0.sig_ref, SEED);
    chk({tag, "_sig_dut"}, b0.sig_dut, SEED);
  endtask

  task automatic fill(input int n_err);
    int k;
    for (int s = 0; s < NS; s++) begin
      ref_v[s] = rand_vec();
      dut_v[s] = ref_v[s];
    end
    for (int n = 0; n < n_err; n++) begin
      k = $urandom_range(0, NS - 1);
      dut_v[k][$urandom_range(0, W - 1)] ^= 1'b1;
    end
  endtask

  task automatic run(input bit stall, input int glitch);
    bit busy_bad = 0;
    bit early    = 0;
    sb.push_back(model());
    @(negedge clk);
    b0.start = 1'b1; b0.in_valid = 1'($urandom_range(0, 1));
    b0.y_ref = rand_vec(); b0.y_dut = rand_vec();
    @(negedge clk);
    b0.start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (stall && k > 0) begin
        repeat (2) begin
          b0.in_valid = 1'b0; b0.y_ref = rand_vec(); b0.y_dut = rand_vec();
          @(negedge clk);
          if (!b0.busy) busy_bad = 1;
          if (b0.done) early = 1;
        end
      end
      b0.in_valid = 1'b1; b0.y_ref = ref_v[k]; b0.y_dut = dut_v[k];
      b0.start = (k == glitch);
      if (b0.done) early = 1;
      @(negedge clk);
      b0.start = 1'b0;
      if (k < NS - 1) begin
        if (!b0.busy) busy_bad = 1;
        if (b0.done) early = 1;
      end
    end
    b0.in_valid = 1'b0;
    chk("busy_during_run", busy_bad, 0);
    chk("done_early", early, 0);
    chk("done_at_last_sample", b0.done, 1);
    chk("busy_after_done", b0.busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    b0.start = 0; b0.in_valid = 0; b0.y_ref = '0; b0.y_dut = '0;
    b1.start = 0; b1.in_valid = 0; b1.y_ref = '0; b1.y_dut = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    fill(0);
    run(0, -1);
    repeat (3) @(negedge clk);
    chk("done_held", b0.done, 1);
    chk("pass_held", b0.pass, 1);

    dut_v[SKIP+7][643] ^= 1'b1;
    run(0, -1);

    for (int s = 0; s < NS; s++) dut_v[s] = ref_v[s];
    dut_v[0][17] ^= 1'b1;
    dut_v[SKIP+3][5] ^= 1'b1;
    dut_v[SKIP+3][100] ^= 1'b1;
    dut_v[SKIP+9][$urandom_range(0, W - 1)] ^= 1'b1;
    run(0, -1);

    for (int s = 0; s < NS; s++) dut_v[s] = ref_v[s];
    run(1, -1);

    fill(3);
    @(negedge clk);
    b0.start = 1'b1; b0.in_valid = 1'b0;
    @(negedge clk);
    b0.start = 1'b0;
    for (int k = 0; k < SKIP + 10; k++) begin
      b0.in_valid = 1'b1; b0.y_ref = ref_v[k]; b0.y_dut = dut_v[k];
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; b0.in_valid = 1'b0;
    check_reset("mid_rst");
    fill(2);
    run(0, -1);

    fill(4);
    run(0, SKIP + 5);
    b0.start = 1'b1; rst = 1'b1;
    @(negedge clk);
    b0.start = 1'b0; rst = 1'b0;
    check_reset("start_rst");

    for (int r = 0; r < 4; r++) begin
      fill($urandom_range(0, 6));
      run(1'($urandom_range(0, 1)), -1);
    end

    b1.start = 1'b1; b1.in_valid = 1'b1; b1.y_ref = '0; b1.y_dut = '0;
    @(negedge clk);
    b1.start = 1'b0;
    chk("one_busy_after_start", b1.busy, 1);
    chk("one_no_accept_on_start", b1.done, 0);
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("one_done", b1.done, 1);
    chk("one_pass", b1.pass, 1);
    chk("one_sig_ref", b1.sig_ref, misr_step(SEED, '0));
    chk("one_sig_dut", b1.sig_dut, misr_step(SEED, '0));

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
